// File: rtl/rndswitch_frame_seq.sv
// Sequenced segment random switch: latches a bitmap, z bit and force_on, then emits
// NB_FRAMES masked frames (seg & mask) ^ {z}, one per accepted random word.
module rndswitch_frame_seq #(
  parameter int NB_SEGMENTS = 120,
  parameter int RND_WIDTH   = 120,
  parameter int NB_FRAMES   = 8,
  localparam int FRAME_W    = (NB_FRAMES > 1) ? $clog2(NB_FRAMES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NB_SEGMENTS-1:0] seg_in,
  input  logic                   z_in,
  input  logic                   force_on,
  output logic                   busy,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  input  logic [RND_WIDTH-1:0]   rnd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NB_SEGMENTS-1:0] out_data,
  output logic [FRAME_W-1:0]     out_frame,
  output logic                   out_last,
  output logic                   done
);

  if (RND_WIDTH < NB_SEGMENTS) begin : g_width_check
    $error("rndswitch_frame_seq: RND_WIDTH must be >= NB_SEGMENTS");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [FRAME_W-1:0] LAST_CNT = FRAME_W'(NB_FRAMES - 1);

  state_t                 state_q, state_d;
  logic [NB_SEGMENTS-1:0] seg_q, seg_d;
  logic                   z_q, z_d;
  logic                   force_q, force_d;
  logic [FRAME_W-1:0]     cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [NB_SEGMENTS-1:0] out_data_q, out_data_d;
  logic [FRAME_W-1:0]     out_frame_q, out_frame_d;
  logic                   out_last_q, out_last_d;
  logic                   done_q, done_d;

  logic                   rnd_ready_c;
  logic                   rnd_xfer;
  logic                   out_xfer;
  logic [NB_SEGMENTS-1:0] mask;
  // Upper random bits are deliberately discarded.
  logic [RND_WIDTH-1:0]   rnd_unused;

  assign rnd_unused  = rnd_data;
  assign rnd_ready_c = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign rnd_xfer    = rnd_valid && rnd_ready_c;
  assign out_xfer    = out_valid_q && out_ready;
  assign mask        = force_q ? {NB_SEGMENTS{1'b1}} : rnd_data[NB_SEGMENTS-1:0];

  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    z_d         = z_q;
    force_d     = force_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_frame_d = out_frame_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          seg_d   = seg_in;
          z_d     = z_in;
          force_d = force_on;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (rnd_xfer) begin
          if (cnt_q == LAST_CNT) state_d = S_DRAIN;
          else                   cnt_d   = cnt_q + FRAME_W'(1);
        end
      end
      S_DRAIN: begin
        if (out_xfer) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Single output register: a reload in the same cycle as a drain keeps it full.
    if (rnd_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = (seg_q & mask) ^ {NB_SEGMENTS{z_q}};
      out_frame_d = cnt_q;
      out_last_d  = (cnt_q == LAST_CNT);
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      seg_q       <= '0;
      z_q         <= 1'b0;
      force_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_frame_q <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      z_q         <= z_d;
      force_q     <= force_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_frame_q <= out_frame_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign rnd_ready = rnd_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_frame = out_frame_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule
